// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage valid/ready register pipeline with bubble squeezing and flush.
// Define ELASTIC_PIPE_SKID_EN to add a registered-ready input skid entry (capacity DEPTH+1).
module elastic_pipe #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH+2);
    logic [DEPTH-1:0] v, rdy, src_v;
    logic [DW-1:0]    d     [DEPTH];
    logic [DW-1:0]    src_d [DEPTH];
    logic             all_v;
    logic             acc;
`ifdef ELASTIC_PIPE_SKID_EN
    logic             skid_v;
    logic [DW-1:0]    skid_d;
    assign in_ready = !skid_v;
`else
    assign in_ready = rdy[0] && !flush;
`endif
    assign acc       = in_valid && in_ready;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];
    // rdy[i] = !v[i] || rdy[i+1], unrolled as "some stage at or after i is empty"
    always_comb begin
        all_v = 1'b1;
        for (int i = DEPTH-1; i >= 0; i--) begin
            all_v  = all_v && v[i];
            rdy[i] = out_ready || !all_v;
        end
`ifdef ELASTIC_PIPE_SKID_EN
        src_v[0]  = skid_v || acc;
        src_d[0]  = skid_v ? skid_d : in_data;
        occupancy = OW'(skid_v);
`else
        src_v[0]  = acc;
        src_d[0]  = in_data;
        occupancy = '0;
`endif
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + OW'(v[i]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++)
                d[i] <= '0;
`ifdef ELASTIC_PIPE_SKID_EN
            skid_v <= 1'b0;
            skid_d <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (rdy[i]) begin
                    v[i] <= src_v[i];
                    if (src_v[i])
                        d[i] <= src_d[i];
                end
`ifdef ELASTIC_PIPE_SKID_EN
            if (skid_v)
                skid_v <= !rdy[0];
            else if (acc && !rdy[0]) begin
                skid_v <= 1'b1;
                skid_d <= in_data;
            end
`endif
        end
    end
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: table vectors, hand sequences and randomized traffic against a queue scoreboard.
module tb_elastic_pipe;
    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int OW    = $clog2(DEPTH+2);
`ifdef ELASTIC_PIPE_SKID_EN
    localparam bit SKID  = 1'b1;
`else
    localparam bit SKID  = 1'b0;
`endif
    localparam int CAP   = DEPTH + (SKID ? 1 : 0);

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        int            e_occ;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [OW-1:0] occupancy;

    int            n_cmp = 0, n_bad = 0, cyc_n = 0;
    logic [DW-1:0] sb [$];
    logic          s_ir, s_ov;
    logic [DW-1:0] s_od;
    logic [OW-1:0] s_occ;
    vec_t          tbl [$];

    elastic_pipe #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, account handshakes in the scoreboard
    task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic fl, input logic rn);
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst_n = rn;
        #1;
        s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_occ = occupancy;
        cyc_n++;
        if (rn) chk("occupancy", int'(occupancy), sb.size());
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_output", 1, 0);
            else chk("out_data", int'(out_data), int'(sb.pop_front()));
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        if (fl || !rn) sb.delete();
    endtask

    initial begin
        int first_in, first_out, lat;
        for (int k = 0; k <= CAP; k++)
            tbl.push_back('{iv: 1'b1, id: DW'(8'h10 + k), ordy: 1'b0,
                            e_ir: (k < CAP), e_ov: (k >= DEPTH), e_occ: k});
        for (int k = 0; k < CAP; k++)
            tbl.push_back('{iv: 1'b0, id: '0, ordy: 1'b1,
                            e_ir: SKID ? (k > 0) : 1'b1, e_ov: 1'b1, e_occ: CAP - k});
        tbl.push_back('{iv: 1'b0, id: '0, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_occ: 0});

        repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_out_valid", s_ov, 0);
        chk("reset_out_data", s_od, 0);
        chk("reset_occupancy", s_occ, 0);
        chk("reset_in_ready", s_ir, 1);

        // Fill with out_ready=0 until backpressure, then drain in order
        foreach (tbl[i]) begin
            cyc(tbl[i].iv, tbl[i].id, tbl[i].ordy, 1'b0, 1'b1);
            chk("tbl_in_ready", s_ir, tbl[i].e_ir);
            chk("tbl_out_valid", s_ov, tbl[i].e_ov);
            chk("tbl_occupancy", s_occ, tbl[i].e_occ);
        end

        // Full-rate stream: latency DEPTH, one output per cycle
        first_in = -1; first_out = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
            if (first_in < 0 && s_ir) first_in = cyc_n;
            if (first_out < 0 && s_ov) first_out = cyc_n;
            if (i > DEPTH) begin
                chk("stream_occupancy", s_occ, DEPTH);
                chk("stream_out_valid", s_ov, 1);
            end
        end
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
            if (first_out < 0 && s_ov) first_out = cyc_n;
        end
        chk("stream_latency", first_out - first_in, DEPTH);
        chk("stream_drained", sb.size(), 0);

        // Bubble: second entry must close up behind the stalled head
        cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
        repeat (DEPTH) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
        chk("bubble_in_ready", s_ir, 1);
        for (int t = 0; t < DEPTH; t++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
            chk("bubble_occupancy", s_occ, 2);
            chk("bubble_head", s_od, 8'hA1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("bubble_squeeze_valid", s_ov, 1);
        chk("bubble_squeeze_data", s_od, 8'hB2);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Flush on a full pipe with both handshakes offered
        repeat (CAP) cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        chk("flush_out_valid", s_ov, 0);
        chk("flush_in_ready", s_ir, 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("post_flush_occupancy", s_occ, 0);
        chk("post_flush_out_valid", s_ov, 0);
        chk("post_flush_out_data", s_od, 0);
        chk("post_flush_in_ready", s_ir, 1);

        // Reset mid-stream, then a fresh push sees full latency
        cyc(1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h32, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("midreset_out_valid", s_ov, 0);
        chk("midreset_occupancy", s_occ, 0);
        chk("midreset_in_ready", s_ir, 1);
        chk("midreset_out_data", s_od, 0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        lat = 0;
        do begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
            lat++;
        end while (!s_ov && lat < 20);
        chk("midreset_push_latency", lat, DEPTH);

        // Random valid/ready/flush traffic
        for (int t = 0; t < 3000; t++) begin
            cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63) == 0, 1'b1);
            chk("random_occ_le_cap", int'(s_occ <= OW'(CAP)), 1);
        end
        for (int t = 0; t < 40 && sb.size() > 0; t++)
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("random_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
